// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
//   SPI_DATA_W  : bits per SPI word
//   spi_mode_t  : {cpol, cpha}, bit order matches the 2-bit mode input
//   spi_state_t : frame state (idle / active)
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous input, with
// single-cycle edge pulses derived from the last stage.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_d          : asynchronous input
//   o_q          : synchronized level
//   o_rise/o_fall: one-cycle pulses on synchronized edges
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_chain[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave (modes 0-3, MSB first) oversampled by Pclk.
//   Pclk, Preset : system clock, asynchronous active-high reset
//   mode         : {CPOL, CPHA}, captured at cs fall
//   tx_data/tx_load/tx_ready : single-entry TX buffer write port
//   rx_data/rx_valid         : last received byte and its one-cycle strobe
//   underrun     : one-cycle pulse when a byte starts with empty TX buffer
//   busy         : frame in progress
//   cs, sclk, mosi, miso     : SPI pins (cs active-low)
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Pclk,
  input  logic                  Preset,
  input  logic [1:0]            mode,
  input  logic [SPI_DATA_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  busy,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso
);

  localparam int CNT_W = $clog2(SPI_DATA_W);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_q;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(Pclk), .i_rst(Preset), .i_d(sclk),
    .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(Pclk), .i_rst(Preset), .i_d(cs),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(Pclk), .i_rst(Preset), .i_d(mosi),
    .o_q(w_mosi_q), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  spi_state_t            r_state;
  spi_mode_t             r_mode;
  logic [SPI_DATA_W-1:0] r_tx_buf;
  logic [SPI_DATA_W-1:0] r_tx_shift;
  logic [SPI_DATA_W-1:0] r_rx_shift;
  logic [SPI_DATA_W-1:0] r_rx_data;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_tx_ready;
  logic                  r_miso;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_busy;
  logic                  r_skip;          // suppress next shift edge (bit7 already on miso)
  logic                  r_pend_underrun; // reload found buffer empty; report when next byte starts
  logic                  r_armed;
  logic [SYNC_STAGES-1:0] r_settle;

  logic                  w_active, w_lead, w_trail;
  logic                  w_enter, w_leave, w_sample, w_shift, w_byte_done;
  logic                  w_consume, w_accept;
  logic [SPI_DATA_W-1:0] w_load_byte;

  always_comb begin
    w_active    = (r_state == ST_ACTIVE);
    w_lead      = r_mode.cpol ? w_sclk_fall : w_sclk_rise;
    w_trail     = r_mode.cpol ? w_sclk_rise : w_sclk_fall;
    w_enter     = (r_state == ST_IDLE) & w_cs_fall & r_armed;
    w_leave     = w_active & w_cs_rise;
    w_sample    = w_active & ~w_cs_rise & (r_mode.cpha ? w_trail : w_lead);
    w_shift     = w_active & ~w_cs_rise & (r_mode.cpha ? w_lead : w_trail);
    w_byte_done = w_sample & (r_bit_cnt == CNT_W'(SPI_DATA_W - 1));
    w_consume   = w_enter | w_byte_done;
    w_accept    = tx_load & r_tx_ready;
    w_load_byte = r_tx_ready ? '1 : r_tx_buf;
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      r_state         <= ST_IDLE;
      r_mode          <= '0;
      r_tx_buf        <= '0;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_rx_data       <= '0;
      r_bit_cnt       <= '0;
      r_tx_ready      <= 1'b1;
      r_miso          <= 1'b0;
      r_rx_valid      <= 1'b0;
      r_underrun      <= 1'b0;
      r_busy          <= 1'b0;
      r_skip          <= 1'b0;
      r_pend_underrun <= 1'b0;
      r_armed         <= 1'b0;
      r_settle        <= '0;
    end else begin
      r_rx_valid <= w_byte_done;
      r_underrun <= 1'b0;

      // The cs synchronizer comes out of reset reading "high"; only accept a
      // falling edge once the chain has flushed and a real high was observed,
      // so a cs held low across reset cannot restart the dropped frame.
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      if (r_settle[SYNC_STAGES-1] && w_cs_q) begin
        r_armed <= 1'b1;
      end

      // TX buffer: a consume in the same cycle as an accept takes the old
      // (empty) contents and leaves the new byte buffered.
      if (w_accept) begin
        r_tx_buf <= tx_data;
      end
      if (w_consume) begin
        r_tx_ready <= ~w_accept;
      end else if (w_accept) begin
        r_tx_ready <= 1'b0;
      end

      if (w_enter) begin
        r_state         <= ST_ACTIVE;
        r_busy          <= 1'b1;
        r_mode          <= spi_mode_t'(mode);
        r_tx_shift      <= w_load_byte;
        r_miso          <= w_load_byte[SPI_DATA_W-1];
        r_bit_cnt       <= '0;
        r_skip          <= mode[0];
        r_underrun      <= r_tx_ready;
        r_pend_underrun <= 1'b0;
      end else if (w_leave) begin
        r_state         <= ST_IDLE;
        r_busy          <= 1'b0;
        r_miso          <= 1'b0;
        r_skip          <= 1'b0;
        r_pend_underrun <= 1'b0;
      end else if (w_active) begin
        if (w_lead && r_pend_underrun) begin
          r_underrun      <= 1'b1;
          r_pend_underrun <= 1'b0;
        end
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[SPI_DATA_W-2:0], w_mosi_q};
          r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
        // Reload at the last sample edge puts the next bit7 on miso early;
        // the shift edge that follows is then skipped in both CPHA modes.
        if (w_byte_done) begin
          r_rx_data       <= {r_rx_shift[SPI_DATA_W-2:0], w_mosi_q};
          r_tx_shift      <= w_load_byte;
          r_miso          <= w_load_byte[SPI_DATA_W-1];
          r_skip          <= 1'b1;
          r_pend_underrun <= r_tx_ready;
        end else if (w_shift) begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else begin
            r_miso     <= r_tx_shift[SPI_DATA_W-2];
            r_tx_shift <= {r_tx_shift[SPI_DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign underrun = r_underrun;
  assign busy     = r_busy;
  assign miso     = r_miso;

endmodule
